// File: rtl/sprite_pkg.sv
// sprite_pkg: keycodes, FSM/direction enums and direction helpers shared by the sprite mover.
package sprite_pkg;
    localparam logic [7:0] KEY_UP    = 8'd82;
    localparam logic [7:0] KEY_DOWN  = 8'd81;
    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_SPACE = 8'd44;
    localparam logic [7:0] KEY_PLUS  = 8'd46;
    localparam logic [7:0] KEY_MINUS = 8'd45;

    typedef enum logic [1:0] {STOP, MOVE, PAUSE} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    function automatic dir_t reverse(input dir_t d);
        return d == DIR_UP ? DIR_DOWN : d == DIR_DOWN ? DIR_UP :
               d == DIR_LEFT ? DIR_RIGHT : d == DIR_RIGHT ? DIR_LEFT : DIR_NONE;
    endfunction

    function automatic dir_t key_dir(input logic [7:0] k);
        return k == KEY_UP ? DIR_UP : k == KEY_DOWN ? DIR_DOWN :
               k == KEY_LEFT ? DIR_LEFT : k == KEY_RIGHT ? DIR_RIGHT : DIR_NONE;
    endfunction
endpackage

// File: rtl/sprite_mover_tick.sv
// frame_tick_gen: synchronises the vsync level and emits a one-Clk pulse on its rising edge.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic meta, sync, prev;

    always_ff @(posedge Clk) begin
        if (Reset) {meta, sync, prev} <= '0;
        else       {meta, sync, prev} <= {frame_clk, meta, sync};
    end

    assign tick = sync & ~prev;
endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: keyboard-steered sprite with speed levels, pause and wall clamping.
// Define SPRITE_WRAP_EN to wrap around at the walls instead of clamp-and-reverse.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int X_CENTER  = 320,
    parameter int Y_CENTER  = 240,
    parameter int SIZE      = 4,
    parameter int SPEED_MAX = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [7:0]         Keycode,
    output logic [COORD_W-1:0] SpriteX,
    output logic [COORD_W-1:0] SpriteY,
    output logic [COORD_W-1:0] SpriteS,
    output logic [2:0]         Speed,
    output logic               Moving,
    output logic               Bounce
);
    localparam int W1 = COORD_W + 1;
    localparam logic [W1-1:0] SZ = W1'(SIZE);
`ifdef SPRITE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // Returns {hit, new_position}; the extra bit keeps the wall tests from wrapping.
    function automatic logic [W1-1:0] step(input logic [COORD_W-1:0] p, input logic fwd,
                                           input int lo, input int hi, input logic [2:0] spd);
        logic [W1-1:0] pw, sw, lo_in, hi_in, nx;
        logic hit;
        pw    = {1'b0, p};
        sw    = W1'(spd);
        lo_in = W1'(lo) + SZ;
        hi_in = W1'(hi) - SZ;
        hit   = fwd ? (pw + SZ + sw >= W1'(hi)) : (pw <= lo_in + sw);
        nx    = hit ? ((fwd != WRAP) ? hi_in : lo_in) : fwd ? pw + sw : pw - sw;
        return {hit, nx[COORD_W-1:0]};
    endfunction

    logic               tick, key_ev, steer, horiz, vert, hit;
    logic [7:0]         key_prev;
    logic [2:0]         speed_n;
    logic [W1-1:0]      xs, ys;
    logic [COORD_W-1:0] x_n, y_n;
    state_t             state, state_n;
    dir_t               dir, arrow, dir_n, dir_f;

    frame_tick_gen u_tick (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .tick(tick));

    // Decoded motion is applied in the same tick, so steering never lags a frame.
    always_comb begin
        arrow   = key_dir(Keycode);
        key_ev  = Keycode != key_prev;
        steer   = arrow != DIR_NONE && state != PAUSE;
        dir_n   = steer ? arrow : dir;
        state_n = steer ? MOVE :
                  (key_ev && Keycode == KEY_SPACE && state != STOP) ? (state == MOVE ? PAUSE : MOVE) : state;
        speed_n = (key_ev && Keycode == KEY_PLUS && Speed < 3'(SPEED_MAX)) ? Speed + 3'd1 :
                  (key_ev && Keycode == KEY_MINUS && Speed > 3'd1) ? Speed - 3'd1 : Speed;
        horiz   = dir_n == DIR_LEFT || dir_n == DIR_RIGHT;
        vert    = dir_n == DIR_UP || dir_n == DIR_DOWN;
        xs      = step(SpriteX, dir_n == DIR_RIGHT, X_MIN, X_MAX, speed_n);
        ys      = step(SpriteY, dir_n == DIR_DOWN, Y_MIN, Y_MAX, speed_n);
        hit     = state_n == MOVE && (horiz ? xs[COORD_W] : vert && ys[COORD_W]);
        x_n     = (state_n == MOVE && horiz) ? xs[COORD_W-1:0] : SpriteX;
        y_n     = (state_n == MOVE && vert) ? ys[COORD_W-1:0] : SpriteY;
        dir_f   = (hit && !WRAP) ? reverse(dir_n) : dir_n;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= STOP;
            dir      <= DIR_NONE;
            Speed    <= 3'd1;
            SpriteX  <= COORD_W'(X_CENTER);
            SpriteY  <= COORD_W'(Y_CENTER);
            key_prev <= '0;
            Bounce   <= 1'b0;
        end else begin
            Bounce <= tick && hit;
            if (tick) begin
                state    <= state_n;
                dir      <= dir_f;
                Speed    <= speed_n;
                SpriteX  <= x_n;
                SpriteY  <= y_n;
                key_prev <= Keycode;
            end
        end
    end

    assign Moving  = state == MOVE;
    assign SpriteS = COORD_W'(SIZE);
endmodule
